id_ex_stage: RTL and testbench



---
 rtl/pipe_pkg.sv | 24 ++
 rtl/load_use_detect.sv | 25 ++
 rtl/id_ex_stage.sv | 153 +++++++++++++++
 tb/tb_id_ex_stage.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: ALU operation classes, the zero register and
// the ID/EX control bundle reused by later stages.
package pipe_pkg;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_IMM   = 2'b11
  } aluop_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic   RegWrite;
    logic   MemtoReg;
    logic   MemRead;
    logic   MemWrite;
    logic   ALUSrc;
    logic   RegDst;
    aluop_t ALUOp;
  } id_ex_ctrl_t;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard check between the load sitting in EX and the
// instruction sitting in ID; suppressed while the stage is frozen or flushed.
module load_use_detect
  import pipe_pkg::*;
(
  input  logic       exMemRead,
  input  logic       exValid,
  input  logic [4:0] exRt,
  input  logic       idValid,
  input  logic [4:0] idRs,
  input  logic [4:0] idRt,
  input  logic       freeze,
  input  logic       flush,
  output logic       stall
);

  logic regMatch;

  assign regMatch = (exRt != REG_ZERO) && ((exRt == idRs) || (exRt == idRt));

  // A flush redirects fetch anyway, and a freeze holds everything, so a
  // stall request in either case would only fight the other mechanism.
  assign stall = !freeze && !flush && exMemRead && exValid && idValid && regMatch;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion.
// Optional performance counters enabled by defining ID_EX_PERF_CNT_EN.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic              id_RegWrite_i,
  input  logic              id_MemtoReg_i,
  input  logic              id_MemRead_i,
  input  logic              id_MemWrite_i,
  input  logic              id_ALUSrc_i,
  input  logic              id_RegDst_i,
  input  logic [1:0]        id_ALUOp_i,
  input  logic [DATA_W-1:0] id_data1_i,
  input  logic [DATA_W-1:0] id_data2_i,
  input  logic [DATA_W-1:0] id_imm_i,
  input  logic [4:0]        id_Rs_i,
  input  logic [4:0]        id_Rt_i,
  input  logic [4:0]        id_Rd_i,
  input  logic              flush_i,
  input  logic              freeze_i,
  output logic              ID_EX_RegWrite_o,
  output logic              ID_EX_MemtoReg_o,
  output logic              ID_EX_MemRead_o,
  output logic              ID_EX_MemWrite_o,
  output logic              ID_EX_ALUSrc_o,
  output logic              ID_EX_RegDst_o,
  output logic [1:0]        ID_EX_ALUOp_o,
  output logic [DATA_W-1:0] ID_EX_data1_o,
  output logic [DATA_W-1:0] ID_EX_data2_o,
  output logic [DATA_W-1:0] ID_EX_imm_o,
  output logic [4:0]        ID_EX_RegisterRs_o,
  output logic [4:0]        ID_EX_RegisterRt_o,
  output logic [4:0]        ID_EX_RegisterRd_o,
  output logic              ID_EX_valid_o,
  output logic              hazard_stall_o
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
`endif
);

  id_ex_ctrl_t       ctrlQ;
  id_ex_ctrl_t       loadCtrl;
  logic [DATA_W-1:0] data1Q;
  logic [DATA_W-1:0] data2Q;
  logic [DATA_W-1:0] immQ;
  logic [4:0]        rsQ;
  logic [4:0]        rtQ;
  logic [4:0]        rdQ;
  logic              validQ;
  logic              hazardStall;
  logic              loadBubble;

  load_use_detect uDetect (
    .exMemRead (ctrlQ.MemRead),
    .exValid   (validQ),
    .exRt      (rtQ),
    .idValid   (id_valid_i),
    .idRs      (id_Rs_i),
    .idRt      (id_Rt_i),
    .freeze    (freeze_i),
    .flush     (flush_i),
    .stall     (hazardStall)
  );

  assign loadBubble = flush_i || hazardStall;

  // An empty decode slot enters EX with no side effects, but its data still flows.
  always_comb begin
    loadCtrl = '0;
    if (id_valid_i) begin
      loadCtrl.RegWrite = id_RegWrite_i;
      loadCtrl.MemtoReg = id_MemtoReg_i;
      loadCtrl.MemRead  = id_MemRead_i;
      loadCtrl.MemWrite = id_MemWrite_i;
      loadCtrl.ALUSrc   = id_ALUSrc_i;
      loadCtrl.RegDst   = id_RegDst_i;
      loadCtrl.ALUOp    = aluop_t'(id_ALUOp_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || (!freeze_i && loadBubble)) begin
      ctrlQ  <= '0;
      data1Q <= '0;
      data2Q <= '0;
      immQ   <= '0;
      rsQ    <= REG_ZERO;
      rtQ    <= REG_ZERO;
      rdQ    <= REG_ZERO;
      validQ <= 1'b0;
    end else if (!freeze_i) begin
      ctrlQ  <= loadCtrl;
      data1Q <= id_data1_i;
      data2Q <= id_data2_i;
      immQ   <= id_imm_i;
      rsQ    <= id_valid_i ? id_Rs_i : REG_ZERO;
      rtQ    <= id_valid_i ? id_Rt_i : REG_ZERO;
      rdQ    <= id_valid_i ? id_Rd_i : REG_ZERO;
      validQ <= id_valid_i;
    end
  end

  assign ID_EX_RegWrite_o   = ctrlQ.RegWrite;
  assign ID_EX_MemtoReg_o   = ctrlQ.MemtoReg;
  assign ID_EX_MemRead_o    = ctrlQ.MemRead;
  assign ID_EX_MemWrite_o   = ctrlQ.MemWrite;
  assign ID_EX_ALUSrc_o     = ctrlQ.ALUSrc;
  assign ID_EX_RegDst_o     = ctrlQ.RegDst;
  assign ID_EX_ALUOp_o      = ctrlQ.ALUOp;
  assign ID_EX_data1_o      = data1Q;
  assign ID_EX_data2_o      = data2Q;
  assign ID_EX_imm_o        = immQ;
  assign ID_EX_RegisterRs_o = rsQ;
  assign ID_EX_RegisterRt_o = rtQ;
  assign ID_EX_RegisterRd_o = rdQ;
  assign ID_EX_valid_o      = validQ;
  assign hazard_stall_o     = hazardStall;

`ifdef ID_EX_PERF_CNT_EN
  logic [CNT_W-1:0] stallCnt;
  logic [CNT_W-1:0] bubbleCnt;

  // Saturating event counters; they freeze together with the stage.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stallCnt  <= '0;
      bubbleCnt <= '0;
    end else if (!freeze_i) begin
      if (hazardStall && (stallCnt != '1)) begin
        stallCnt <= stallCnt + 1'b1;
      end
      if (loadBubble && (bubbleCnt != '1)) begin
        bubbleCnt <= bubbleCnt + 1'b1;
      end
    end
  end

  assign stall_cnt_o  = stallCnt;
  assign bubble_cnt_o = bubbleCnt;
`else
  logic [CNT_W-1:0] unusedCntWidth;
  assign unusedCntWidth = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard testbench for id_ex_stage: directed vectors push expected
// results, an independent monitor pops and compares them each cycle.
module tb_id_ex_stage;

  localparam int TB_CNT_W = 4;

  typedef struct {
    logic        valid;
    logic [7:0]  ctrl;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } instr_t;

  typedef struct {
    logic   haz;
    instr_t ex;
    int     stallCnt;
    int     bubbleCnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        idValid;
  logic [7:0]  idCtrl;
  logic [31:0] idData1, idData2, idImm;
  logic [4:0]  idRs, idRt, idRd;
  logic        flush, freeze;

  logic        exRegWrite, exMemtoReg, exMemRead, exMemWrite, exALUSrc, exRegDst;
  logic [1:0]  exALUOp;
  logic [31:0] exData1, exData2, exImm;
  logic [4:0]  exRs, exRt, exRd;
  logic        exValid;
  logic        hazard;
`ifdef ID_EX_PERF_CNT_EN
  logic [TB_CNT_W-1:0] stallCnt, bubbleCnt;
`endif

  exp_t   scoreboard[$];
  int     checkCount = 0;
  int     passCount  = 0;

  instr_t LW8, ADD9, LW0, ADD0, SUB, LW9, USE9, NOPINV, NOPINV_EX, BUB;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(32), .CNT_W(TB_CNT_W)) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .id_valid_i         (idValid),
    .id_RegWrite_i      (idCtrl[7]),
    .id_MemtoReg_i      (idCtrl[6]),
    .id_MemRead_i       (idCtrl[5]),
    .id_MemWrite_i      (idCtrl[4]),
    .id_ALUSrc_i        (idCtrl[3]),
    .id_RegDst_i        (idCtrl[2]),
    .id_ALUOp_i         (idCtrl[1:0]),
    .id_data1_i         (idData1),
    .id_data2_i         (idData2),
    .id_imm_i           (idImm),
    .id_Rs_i            (idRs),
    .id_Rt_i            (idRt),
    .id_Rd_i            (idRd),
    .flush_i            (flush),
    .freeze_i           (freeze),
    .ID_EX_RegWrite_o   (exRegWrite),
    .ID_EX_MemtoReg_o   (exMemtoReg),
    .ID_EX_MemRead_o    (exMemRead),
    .ID_EX_MemWrite_o   (exMemWrite),
    .ID_EX_ALUSrc_o     (exALUSrc),
    .ID_EX_RegDst_o     (exRegDst),
    .ID_EX_ALUOp_o      (exALUOp),
    .ID_EX_data1_o      (exData1),
    .ID_EX_data2_o      (exData2),
    .ID_EX_imm_o        (exImm),
    .ID_EX_RegisterRs_o (exRs),
    .ID_EX_RegisterRt_o (exRt),
    .ID_EX_RegisterRd_o (exRd),
    .ID_EX_valid_o      (exValid),
    .hazard_stall_o     (hazard)
`ifdef ID_EX_PERF_CNT_EN
    ,
    .stall_cnt_o        (stallCnt),
    .bubble_cnt_o       (bubbleCnt)
`endif
  );

  function automatic instr_t mk(input logic v, input logic [7:0] c, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] i,
                                input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
    instr_t r;
    r.valid = v; r.ctrl = c; r.d1 = a; r.d2 = b; r.imm = i; r.rs = s; r.rt = t; r.rd = d;
    return r;
  endfunction

  function automatic instr_t randInstr();
    return mk(1'($urandom), 8'($urandom), $urandom, $urandom, $urandom,
              5'($urandom), 5'($urandom), 5'($urandom));
  endfunction

  function automatic int sat(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end else begin
      passCount++;
    end
  endtask

  task automatic driveId(input instr_t id);
    idValid = id.valid; idCtrl = id.ctrl; idData1 = id.d1; idData2 = id.d2;
    idImm = id.imm; idRs = id.rs; idRt = id.rt; idRd = id.rd;
  endtask

  // Drive one cycle of ID inputs and queue what the monitor should see: the
  // stall flag during this cycle and the EX contents after the next edge.
  task automatic applyStimulus(input instr_t id, input logic fl, input logic fz, input logic rs,
                               input logic expHaz, input instr_t expEx,
                               input int expStall, input int expBubble);
    exp_t e;
    @(negedge clk);
    driveId(id);
    flush = fl; freeze = fz; rst = rs;
    e.haz = expHaz; e.ex = expEx; e.stallCnt = expStall; e.bubbleCnt = expBubble;
    scoreboard.push_back(e);
  endtask

  // Monitor: stall flag mid-low-phase, registered outputs just after the edge.
  initial begin
    exp_t cur;
    forever begin
      @(negedge clk);
      #2;
      if (scoreboard.size() > 0) begin
        cur = scoreboard.pop_front();
        checkOutput("hazard_stall", 32'(hazard), 32'(cur.haz));
        @(posedge clk);
        #1;
        checkOutput("valid", 32'(exValid), 32'(cur.ex.valid));
        checkOutput("ctrl", 32'({exRegWrite, exMemtoReg, exMemRead, exMemWrite,
                                 exALUSrc, exRegDst, exALUOp}), 32'(cur.ex.ctrl));
        checkOutput("data1", exData1, cur.ex.d1);
        checkOutput("data2", exData2, cur.ex.d2);
        checkOutput("imm", exImm, cur.ex.imm);
        checkOutput("RegisterRs", 32'(exRs), 32'(cur.ex.rs));
        checkOutput("RegisterRt", 32'(exRt), 32'(cur.ex.rt));
        checkOutput("RegisterRd", 32'(exRd), 32'(cur.ex.rd));
`ifdef ID_EX_PERF_CNT_EN
        checkOutput("stall_cnt", 32'(stallCnt), 32'(cur.stallCnt));
        checkOutput("bubble_cnt", 32'(bubbleCnt), 32'(cur.bubbleCnt));
`endif
      end
    end
  end

  initial begin
    LW8       = mk(1'b1, 8'hE8, 32'h100, 32'h0, 32'h4, 5'd1, 5'd8, 5'd0);
    ADD9      = mk(1'b1, 8'h86, 32'h11, 32'h22, 32'h4820, 5'd8, 5'd10, 5'd9);
    LW0       = mk(1'b1, 8'hE8, 32'h200, 32'h0, 32'h0, 5'd2, 5'd0, 5'd0);
    ADD0      = mk(1'b1, 8'h86, 32'h0, 32'h0, 32'h1820, 5'd0, 5'd0, 5'd3);
    SUB       = mk(1'b1, 8'h86, 32'h66, 32'h77, 32'h2822, 5'd6, 5'd7, 5'd5);
    LW9       = mk(1'b1, 8'hE8, 32'h300, 32'h0, 32'h0, 5'd8, 5'd9, 5'd0);
    USE9      = mk(1'b1, 8'h86, 32'h99, 32'h99, 32'h2020, 5'd9, 5'd9, 5'd4);
    NOPINV    = mk(1'b0, 8'hFF, 32'hAAAA5555, 32'h12345678, 32'hFFFF0000, 5'd8, 5'd8, 5'd8);
    NOPINV_EX = mk(1'b0, 8'h00, 32'hAAAA5555, 32'h12345678, 32'hFFFF0000, 5'd0, 5'd0, 5'd0);
    BUB       = mk(1'b0, 8'h00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);

    $display("[TB] id_ex_stage scoreboard bench starting");
    rst = 1'b1; flush = 1'b0; freeze = 1'b0;
    driveId(randInstr());
    @(posedge clk);

    // Second reset cycle with random ID contents
    applyStimulus(randInstr(), 1'b0, 1'b0, 1'b1, 1'b0, BUB, 0, 0);

    // Load-use: one stall, bubble, then the dependent add with Rs = 8
    applyStimulus(LW8,  1'b0, 1'b0, 1'b0, 1'b0, LW8,  0, 0);
    applyStimulus(ADD9, 1'b0, 1'b0, 1'b0, 1'b1, BUB,  1, 1);
    applyStimulus(ADD9, 1'b0, 1'b0, 1'b0, 1'b0, ADD9, 1, 1);

    // Load into $0 followed by a reader of $0 never stalls
    applyStimulus(LW0,  1'b0, 1'b0, 1'b0, 1'b0, LW0,  1, 1);
    applyStimulus(ADD0, 1'b0, 1'b0, 1'b0, 1'b0, ADD0, 1, 1);

    // Flush together with a load-use hazard: flush wins, no stall
    applyStimulus(LW8,  1'b0, 1'b0, 1'b0, 1'b0, LW8,  1, 1);
    applyStimulus(ADD9, 1'b1, 1'b0, 1'b0, 1'b0, BUB,  1, 2);

    // Freeze for three cycles with a pending hazard, last one with flush too
    applyStimulus(LW8,  1'b0, 1'b0, 1'b0, 1'b0, LW8,  1, 2);
    applyStimulus(ADD9, 1'b0, 1'b1, 1'b0, 1'b0, LW8,  1, 2);
    applyStimulus(SUB,  1'b0, 1'b1, 1'b0, 1'b0, LW8,  1, 2);
    applyStimulus(ADD9, 1'b1, 1'b1, 1'b0, 1'b0, LW8,  1, 2);
    applyStimulus(SUB,  1'b0, 1'b0, 1'b0, 1'b0, SUB,  1, 2);

    // Back-to-back load-use: load, dependent load, dependent use
    applyStimulus(LW8,  1'b0, 1'b0, 1'b0, 1'b0, LW8,  1, 2);
    applyStimulus(LW9,  1'b0, 1'b0, 1'b0, 1'b1, BUB,  2, 3);
    applyStimulus(LW9,  1'b0, 1'b0, 1'b0, 1'b0, LW9,  2, 3);
    applyStimulus(USE9, 1'b0, 1'b0, 1'b0, 1'b1, BUB,  3, 4);
    applyStimulus(USE9, 1'b0, 1'b0, 1'b0, 1'b0, USE9, 3, 4);

    // Reset while a stall is being requested
    applyStimulus(LW8,  1'b0, 1'b0, 1'b0, 1'b0, LW8,  3, 4);
    applyStimulus(ADD9, 1'b0, 1'b0, 1'b1, 1'b1, BUB,  0, 0);
    applyStimulus(ADD9, 1'b0, 1'b0, 1'b0, 1'b0, ADD9, 0, 0);

    // Empty decode slot naming the loaded register: no stall, zeroed control
    applyStimulus(LW8,    1'b0, 1'b0, 1'b0, 1'b0, LW8,       0, 0);
    applyStimulus(NOPINV, 1'b0, 1'b0, 1'b0, 1'b0, NOPINV_EX, 0, 0);

    // Twenty separate load-use hazards; 4-bit counters saturate at 15
    for (int i = 1; i <= 20; i++) begin
      applyStimulus(LW8,  1'b0, 1'b0, 1'b0, 1'b0, LW8, sat(i - 1), sat(i - 1));
      applyStimulus(ADD9, 1'b0, 1'b0, 1'b0, 1'b1, BUB, sat(i), sat(i));
    end

    for (int i = 0; i < 20 && scoreboard.size() > 0; i++) @(posedge clk);
    if (scoreboard.size() > 0) begin
      checkCount++;
      $display("[TB] FAIL drain: %0d entries left, required 0", scoreboard.size());
    end
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
